seq_detect_ctrl: RTL and testbench

Programmable serial-pattern detection controller for the FSM block group. It holds a run-time configured PAT_W-bit target pattern, an overlap/non-overlap mode and a match threshold. It matches a handshaked serial bit stream against the pattern, counts matches and raises a sticky interrupt when the threshold is reached. It sits between the register/config interface and the serial input path, sequencing configure → run → done.

---
 rtl/seq_detect_pkg.sv | 26 ++
 rtl/seq_detect_ctrl_if.sv | 38 +++
 rtl/seq_match_core.sv | 60 ++++++
 rtl/seq_detect_ctrl.sv | 144 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the serial-pattern detection controller:
//   - control FSM state encoding
//   - default pattern length and match-counter width
//   - width of the history fill counter, which must hold 0..PAT_W
// ---------------------------------------------------------------------------
package seq_detect_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The fill counter counts up to and including PAT_W.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam int FILL_W_DEF = fill_width(PAT_W_DEF);

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl_if
// Config and serial-data channels of the detection controller.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high. ready depends only on controller
// state, never on valid. A source may raise valid at any time and nothing is
// buffered: a beat offered while ready is low is dropped, not held.
//   cfg channel : cfg_valid / cfg_ready, payload cfg_pattern, cfg_overlap,
//                 cfg_threshold (ready only while idle).
//   data channel: din_valid / din_ready, payload din (ready only while running).
// master = the config/stream source, slave = seq_detect_ctrl.
// ---------------------------------------------------------------------------
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_threshold;
    logic             din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output cfg_valid, cfg_pattern, cfg_overlap, cfg_threshold,
        output din, din_valid,
        input  cfg_ready, din_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_overlap, cfg_threshold,
        input  din, din_valid,
        output cfg_ready, din_ready
    );
endinterface

// File: rtl/seq_match_core.sv
// ---------------------------------------------------------------------------
// seq_match_core
// Shift-register history and pattern compare.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   shift_en     : one accepted serial bit this cycle
//   clear        : drop history (start of a run); wins over shift_en
//   din          : serial bit, shifted in at the LSB (MSB = oldest)
//   pattern      : target pattern
//   overlap      : 1 = keep history after a hit, 0 = restart fill after a hit
//   hit          : combinational strobe, the bit being shifted completes a match
// ---------------------------------------------------------------------------
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);
    localparam int                FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  shreg_q, shreg_d, shifted;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

    always_comb begin
        shifted  = {shreg_q[PAT_W-2:0], din};
        // fill saturates at PAT_W: in overlap mode it then stays full.
        fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        hit      = shift_en && !clear && (fill_inc == FILL_FULL) && (shifted == pattern);

        shreg_d = shreg_q;
        fill_d  = fill_q;
        if (clear) begin
            shreg_d = '0;
            fill_d  = '0;
        end else if (shift_en) begin
            shreg_d = shifted;
            // Non-overlap: the next match needs PAT_W fresh bits.
            fill_d  = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
// Programmable serial-pattern detection controller: configure -> run -> done.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   bus          : config and serial-data channels (slave side)
//   start        : begin a run, clears count and history (from IDLE or DONE)
//   stop         : end/abort a run, back to IDLE; wins over start
//   irq_clr      : clear sticky irq; a same-cycle set wins
//   match        : registered one-cycle pulse per detected pattern
//   match_count  : saturating match count since last start
//   irq          : sticky, set when the count reaches a non-zero threshold
//   busy         : state != IDLE
//   dbg_state    : current FSM state
// ---------------------------------------------------------------------------
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    seq_detect_ctrl_if.slave bus,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             irq,
    output logic             busy,
    output state_t           dbg_state
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] threshold_q, threshold_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             match_q, match_d;
    logic             irq_q, irq_d;

    logic cfg_ready_w, din_ready_w, busy_w, start_go;
    logic accept, hit, irq_set;

    // ---- state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ---- output decode (from the state register only) ----
    always_comb begin
        cfg_ready_w = (state_q == ST_IDLE);
        din_ready_w = (state_q == ST_RUN);
        busy_w      = (state_q != ST_IDLE);
        // start is honoured from IDLE or DONE; ignored while running.
        start_go    = (state_q != ST_RUN) && start && !stop;
    end

    assign accept = bus.din_valid && din_ready_w;

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (accept),
        .clear    (start_go),
        .din      (bus.din),
        .pattern  (pattern_q),
        .overlap  (overlap_q),
        .hit      (hit)
    );

    // ---- counter / irq datapath ----
    always_comb begin
        count_inc = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
        irq_set   = hit && (threshold_q != '0) && (count_inc == threshold_q);

        count_d = count_q;
        if (start_go)  count_d = '0;
        else if (hit)  count_d = count_inc;

        irq_d = irq_q;
        if (irq_set)      irq_d = 1'b1;
        else if (irq_clr) irq_d = 1'b0;

        match_d = hit;

        pattern_d   = pattern_q;
        overlap_d   = overlap_q;
        threshold_d = threshold_q;
        // Latching in the start cycle means the run uses the new config.
        if (cfg_ready_w && bus.cfg_valid) begin
            pattern_d   = bus.cfg_pattern;
            overlap_d   = bus.cfg_overlap;
            threshold_d = bus.cfg_threshold;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_go) state_d = ST_RUN;
            // A bit accepted alongside stop is still processed above.
            ST_RUN: begin
                if (stop)         state_d = ST_IDLE;
                else if (irq_set) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (stop)          state_d = ST_IDLE;
                else if (start_go) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q   <= '0;
            overlap_q   <= 1'b0;
            threshold_q <= '0;
            count_q     <= '0;
            match_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            overlap_q   <= overlap_d;
            threshold_q <= threshold_d;
            count_q     <= count_d;
            match_q     <= match_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_w;
    assign bus.din_ready = din_ready_w;
    assign busy          = busy_w;
    assign match         = match_q;
    assign match_count   = count_q;
    assign irq           = irq_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
// Directed bench for seq_detect_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are observed at the same point, i.e. they show the
// result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;
    import seq_detect_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, stop, irq_clr;
    logic       match, irq, busy;
    logic [7:0] match_count;
    state_t     dbg_state;

    int n_total = 0;
    int n_fail  = 0;

    seq_detect_ctrl_if #(.PAT_W(4), .CNT_W(8)) bus_if ();

    seq_detect_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .start       (start),
        .stop        (stop),
        .irq_clr     (irq_clr),
        .match       (match),
        .match_count (match_count),
        .irq         (irq),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    // ---- driver tasks ----
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic configure(input logic [3:0] pat, input logic ovl, input logic [7:0] thr);
        bus_if.cfg_valid     = 1'b1;
        bus_if.cfg_pattern   = pat;
        bus_if.cfg_overlap   = ovl;
        bus_if.cfg_threshold = thr;
        cycle();
        bus_if.cfg_valid     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    // Sends n bits of 'bits' (index n-1 first) and checks match after each.
    task automatic run_stream(input string tag, input logic [6:0] bits,
                              input logic [6:0] exp_m, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus_if.din       = bits[i];
            bus_if.din_valid = 1'b1;
            cycle();
            bus_if.din_valid = 1'b0;
            chk($sformatf("%s_match_bit%0d", tag, n - i), {31'd0, match}, {31'd0, exp_m[i]});
        end
    endtask

    initial begin
        // ---- reset ----
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        bus_if.cfg_valid = 1'b0; bus_if.cfg_pattern = '0;
        bus_if.cfg_overlap = 1'b0; bus_if.cfg_threshold = '0;
        bus_if.din = 1'b0; bus_if.din_valid = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        cycle();
        chk("rst_state",     32'(dbg_state), 32'(ST_IDLE));
        chk("rst_cfg_ready", {31'd0, bus_if.cfg_ready}, 32'd1);
        chk("rst_din_ready", {31'd0, bus_if.din_ready}, 32'd0);
        chk("rst_match",     {31'd0, match}, 32'd0);
        chk("rst_count",     {24'd0, match_count}, 32'd0);
        chk("rst_irq",       {31'd0, irq}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);

        // ---- non-overlap 1001 over 1001001: one match ----
        configure(4'b1001, 1'b0, 8'd0);
        do_start();
        chk("no_busy",      {31'd0, busy}, 32'd1);
        chk("no_din_ready", {31'd0, bus_if.din_ready}, 32'd1);
        run_stream("nonovl", 7'b1001001, 7'b0001000, 7);
        chk("no_count", {24'd0, match_count}, 32'd1);
        do_stop();
        chk("no_stop_busy",  {31'd0, busy}, 32'd0);
        chk("no_stop_count", {24'd0, match_count}, 32'd1);

        // ---- overlap, same stream: two matches ----
        configure(4'b1001, 1'b1, 8'd0);
        do_start();
        chk("ov_count_clr", {24'd0, match_count}, 32'd0);
        run_stream("ovl", 7'b1001001, 7'b0001001, 7);
        chk("ov_count", {24'd0, match_count}, 32'd2);
        do_stop();

        // ---- threshold 2, config written in the start cycle ----
        bus_if.cfg_valid = 1'b1; bus_if.cfg_pattern = 4'b1001;
        bus_if.cfg_overlap = 1'b1; bus_if.cfg_threshold = 8'd2;
        start = 1'b1;
        cycle();
        bus_if.cfg_valid = 1'b0; start = 1'b0;
        chk("thr_state_run", 32'(dbg_state), 32'(ST_RUN));
        run_stream("thr", 7'b1001001, 7'b0001001, 7);
        chk("thr_irq",       {31'd0, irq}, 32'd1);
        chk("thr_state",     32'(dbg_state), 32'(ST_DONE));
        chk("thr_din_ready", {31'd0, bus_if.din_ready}, 32'd0);
        chk("thr_count",     {24'd0, match_count}, 32'd2);
        run_stream("done_ign", 7'b0001001, 7'b0000000, 4);
        chk("done_count", {24'd0, match_count}, 32'd2);
        do_start();
        chk("restart_state", 32'(dbg_state), 32'(ST_RUN));
        chk("restart_count", {24'd0, match_count}, 32'd0);
        chk("restart_irq",   {31'd0, irq}, 32'd1);
        irq_clr = 1'b1;
        cycle();
        irq_clr = 1'b0;
        chk("irq_clr", {31'd0, irq}, 32'd0);
        do_stop();

        // ---- cfg write during RUN is ignored ----
        do_start();
        chk("run_cfg_ready", {31'd0, bus_if.cfg_ready}, 32'd0);
        bus_if.cfg_valid = 1'b1; bus_if.cfg_pattern = 4'b0110;
        bus_if.cfg_overlap = 1'b0; bus_if.cfg_threshold = 8'd0;
        cycle();
        bus_if.cfg_valid = 1'b0;
        run_stream("keepcfg", 7'b0001001, 7'b0000001, 4);
        chk("keepcfg_count", {24'd0, match_count}, 32'd1);
        do_stop();

        // ---- 0110 written in IDLE is used by the next run ----
        configure(4'b0110, 1'b0, 8'd0);
        do_start();
        run_stream("p0110", 7'b0000110, 7'b0000001, 4);
        chk("p0110_count", {24'd0, match_count}, 32'd1);

        // ---- stop together with the completing bit ----
        run_stream("stopm", 7'b0000011, 7'b0000000, 3);
        bus_if.din = 1'b0; bus_if.din_valid = 1'b1; stop = 1'b1;
        cycle();
        bus_if.din_valid = 1'b0; stop = 1'b0;
        chk("stopm_match", {31'd0, match}, 32'd1);
        chk("stopm_count", {24'd0, match_count}, 32'd2);
        chk("stopm_busy",  {31'd0, busy}, 32'd0);
        chk("stopm_state", 32'(dbg_state), 32'(ST_IDLE));

        // ---- async reset mid-pattern ----
        configure(4'b1001, 1'b1, 8'd0);
        do_start();
        run_stream("prerst", 7'b0100100, 7'b0000100, 6);
        chk("prerst_count", {24'd0, match_count}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_state",     32'(dbg_state), 32'(ST_IDLE));
        chk("arst_count",     {24'd0, match_count}, 32'd0);
        chk("arst_busy",      {31'd0, busy}, 32'd0);
        chk("arst_cfg_ready", {31'd0, bus_if.cfg_ready}, 32'd1);
        chk("arst_din_ready", {31'd0, bus_if.din_ready}, 32'd0);
        chk("arst_match",     {31'd0, match}, 32'd0);
        chk("arst_irq",       {31'd0, irq}, 32'd0);
        cycle();
        reset_n = 1'b1;
        cycle();
        configure(4'b1001, 1'b1, 8'd0);
        do_start();
        run_stream("postrst", 7'b0001001, 7'b0000001, 4);
        chk("postrst_count", {24'd0, match_count}, 32'd1);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end
endmodule
